// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller slice.
//   - Width range macros for PC and logical register index buses.
//   - Default parameter values for the controller.
//   - dcache handshake FSM state encoding.
//   - Packed bundle of the stall/flush/redirect controls built by the
//     priority mux.
`ifndef PC_RANGE
`define PC_RANGE PC_WIDTH-1:0
`endif
`ifndef LREG_RANGE
`define LREG_RANGE LREG_WIDTH-1:0
`endif

package pipe_hazard_ctrl_pkg;

    localparam int PC_WIDTH_DEF   = 64;
    localparam int LREG_WIDTH_DEF = 5;
    localparam int MULDIV_LAT_DEF = 4;

    // dcache handshake FSM encoding (kept as plain constants for
    // compatibility with existing state decoders in the codebase).
    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_REQ  = 2'd1;
    localparam logic [1:0] M_WAIT = 2'd2;

    typedef struct packed {
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic stall_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
        logic redirect;
    } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the hazard controller, the dcache and the IFU.
//   mem_req_valid      : controller -> dcache request
//   mem_req_ready      : dcache accepts request
//   mem_resp_valid     : dcache response/ack
//   fe_redirect_valid  : controller -> IFU redirect
//   fe_redirect_target : redirect PC
// master = hazard controller side, slave = dcache/IFU side.
interface pipe_hazard_ctrl_if #(
    parameter int PC_WIDTH = pipe_hazard_ctrl_pkg::PC_WIDTH_DEF
);
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_resp_valid;
    logic                 fe_redirect_valid;
    logic [`PC_RANGE]     fe_redirect_target;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        input  mem_resp_valid,
        output fe_redirect_valid,
        output fe_redirect_target
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        output mem_resp_valid,
        input  fe_redirect_valid,
        input  fe_redirect_target
    );
endinterface

// File: rtl/pipe_hazard_ctrl_dcache_hs_fsm.sv
// dcache request/response handshake sequencer for the MEM stage.
//   clock, reset_n    : clock, async active-low reset
//   mem_instr_valid   : MEM-stage instruction valid
//   mem_is_ls         : MEM instruction is a load or store
//   mem_req_ready     : dcache accepts request
//   mem_resp_valid    : dcache response (only sampled while waiting)
//   mem_req_valid     : dcache request
//   mem_stall         : MEM access still in flight, whole pipe must hold
module dcache_hs_fsm
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic mem_instr_valid,
    input  logic mem_is_ls,
    input  logic mem_req_ready,
    input  logic mem_resp_valid,
    output logic mem_req_valid,
    output logic mem_stall
);

    logic [1:0] state_q;
    logic [1:0] state_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path through the case leaves a latch behind.
        state_d       = state_q;
        mem_req_valid = 1'b0;
        mem_stall     = 1'b0;
        case (state_q)
            M_IDLE: begin
                if (mem_instr_valid && mem_is_ls) begin
                    mem_req_valid = 1'b1;
                    mem_stall     = 1'b1;
                    state_d       = mem_req_ready ? M_WAIT : M_REQ;
                end
            end
            M_REQ: begin
                mem_req_valid = 1'b1;
                mem_stall     = 1'b1;
                if (mem_req_ready) state_d = M_WAIT;
            end
            M_WAIT: begin
                // The response cycle itself releases the pipe.
                mem_stall = ~mem_resp_valid;
                if (mem_resp_valid) state_d = M_IDLE;
            end
            default: state_d = M_IDLE;
        endcase
    end

    // NOTE: asynchronous active-low reset; state uses non-blocking
    // assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= M_IDLE;
        else          state_q <= state_d;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the in-order IF/ID/EX/MEM/WB backend.
// Resolves, in priority order: dcache handshake, muldiv occupancy,
// load-use, branch redirect. A redirect arriving while the pipe is held
// by the dcache is parked and issued in the first unstalled cycle.
//   clock, reset_n        : clock, async active-low reset
//   id_* / ex_* / mem_*   : per-stage instruction info
//   redirect_in_*         : mispredict pulse + corrected PC from the BJU
//   dc_fe (master)        : dcache handshake and IFU redirect
//   muldiv_result_valid   : muldiv result final this cycle
//   stall_* / flush_*     : pipeline register controls
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int LREG_WIDTH = LREG_WIDTH_DEF,
    parameter int MULDIV_LAT = MULDIV_LAT_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_instr_valid,
    input  logic [`LREG_RANGE] id_rs1,
    input  logic [`LREG_RANGE] id_rs2,
    input  logic              id_src1_is_reg,
    input  logic              id_src2_is_reg,
    input  logic              ex_instr_valid,
    input  logic              ex_is_load,
    input  logic [`LREG_RANGE] ex_rd,
    input  logic              ex_is_muldiv,
    input  logic              mem_instr_valid,
    input  logic              mem_is_ls,
    input  logic              redirect_in_valid,
    input  logic [`PC_RANGE]  redirect_in_target,
    pipe_hazard_ctrl_if.master dc_fe,
    output logic              muldiv_result_valid,
    output logic              stall_if_id,
    output logic              stall_id_ex,
    output logic              stall_ex_mem,
    output logic              stall_mem_wb,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem
);

    // Outputs stay quiet during reset and for the first cycle after
    // release; gating the valids keeps all state idle in that cycle too.
    logic out_en;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) out_en <= 1'b0;
        else          out_en <= 1'b1;
    end

    logic id_v, ex_v, mem_v, rdr_v;
    assign id_v  = id_instr_valid    & out_en;
    assign ex_v  = ex_instr_valid    & out_en;
    assign mem_v = mem_instr_valid   & out_en;
    assign rdr_v = redirect_in_valid & out_en;

    logic mem_stall;
    logic mem_req_valid_w;
    dcache_hs_fsm u_dcache_hs_fsm (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_instr_valid(mem_v),
        .mem_is_ls      (mem_is_ls),
        .mem_req_ready  (dc_fe.mem_req_ready),
        .mem_resp_valid (dc_fe.mem_resp_valid),
        .mem_req_valid  (mem_req_valid_w),
        .mem_stall      (mem_stall)
    );
    assign dc_fe.mem_req_valid = mem_req_valid_w;

    hz_ctrl_t ctrl;
    logic     md_stall;
    logic     md_fire;

    generate
        if (MULDIV_LAT > 0) begin : g_md
            localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
            logic [CW-1:0] md_cnt;
            logic          md_done;
            logic          md_start;

            // md_done blocks a second start by the same instruction while
            // it is still sitting in EX after its result is final.
            assign md_start = ex_v & ex_is_muldiv & ~md_done & (md_cnt == '0);
            assign md_stall = md_start | (md_cnt != '0);
            assign md_fire  = (md_cnt == CW'(1)) | (md_start & (MULDIV_LAT == 1));

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    md_cnt  <= '0;
                    md_done <= 1'b0;
                end else begin
                    if (md_start)            md_cnt <= CW'(MULDIV_LAT - 1);
                    else if (md_cnt != '0)   md_cnt <= md_cnt - CW'(1);
                    if (md_fire)             md_done <= 1'b1;
                    else if (!ctrl.stall_id_ex) md_done <= 1'b0;
                end
            end
        end else begin : g_no_md
            assign md_stall = 1'b0;
            assign md_fire  = 1'b0;
        end
    endgenerate

    logic load_use;
    assign load_use = id_v & ex_v & ex_is_load & (ex_rd != '0) &
                      ((id_src1_is_reg & (id_rs1 == ex_rd)) |
                       (id_src2_is_reg & (id_rs2 == ex_rd)));

    logic             pend_v;
    logic [`PC_RANGE] pend_t;
    logic             redirect_now;
    logic [`PC_RANGE] redirect_tgt;
    assign redirect_now = rdr_v | pend_v;
    assign redirect_tgt = rdr_v ? redirect_in_target : pend_t;

    always_comb begin
        ctrl = '0;
        if (mem_stall) begin
            ctrl.stall_if_id  = 1'b1;
            ctrl.stall_id_ex  = 1'b1;
            ctrl.stall_ex_mem = 1'b1;
            ctrl.stall_mem_wb = 1'b1;
        end else if (md_stall) begin
            ctrl.stall_if_id  = 1'b1;
            ctrl.stall_id_ex  = 1'b1;
            ctrl.flush_ex_mem = 1'b1;
        end else if (load_use) begin
            ctrl.stall_if_id  = 1'b1;
            ctrl.flush_id_ex  = 1'b1;
        end else if (redirect_now) begin
            ctrl.flush_if_id  = 1'b1;
            ctrl.flush_id_ex  = 1'b1;
            ctrl.redirect     = 1'b1;
        end
    end

    // A stalled register ignores flush, so a redirect seen under a dcache
    // stall is parked here until it can actually be issued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_v <= 1'b0;
            pend_t <= '0;
        end else if (rdr_v && mem_stall) begin
            pend_v <= 1'b1;
            pend_t <= redirect_in_target;
        end else if (ctrl.redirect) begin
            pend_v <= 1'b0;
        end
    end

    assign stall_if_id              = ctrl.stall_if_id;
    assign stall_id_ex              = ctrl.stall_id_ex;
    assign stall_ex_mem             = ctrl.stall_ex_mem;
    assign stall_mem_wb             = ctrl.stall_mem_wb;
    assign flush_if_id              = ctrl.flush_if_id;
    assign flush_id_ex              = ctrl.flush_id_ex;
    assign flush_ex_mem             = ctrl.flush_ex_mem;
    assign muldiv_result_valid      = md_fire;
    assign dc_fe.fe_redirect_valid  = ctrl.redirect;
    assign dc_fe.fe_redirect_target = ctrl.redirect ? redirect_tgt : '0;

    // The BJU never resolves a mispredict while EX is held by muldiv or
    // while ID is being bubbled for load-use.
    a_no_redirect_under_ex_hold : assert property (
        @(posedge clock) disable iff (!reset_n)
        !(rdr_v && (md_stall || load_use))
    ) else $error("redirect_in_valid during muldiv_stall or load_use");

endmodule
